// File: rtl/membus_arbiter.sv
// membus_arbiter
//   Shares one downstream membus master between two requesters (port 0: CPU
//   core, port 1: boot loader / draw DMA). Round-robin arbitration with the
//   request and response paths forwarded combinationally. Accepted requests
//   are tracked in a grant-ID FIFO so in-order responses reach their owner.
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   m0_* / m1_*         requester ports: valid/ready handshake, addr, wen,
//                       wdata, wmask; rvalid/rdata response
//   s_*                 downstream request (muxed fields) and response
//   outstanding         accepted-but-unanswered request count
//   err_orphan          sticky flag: response arrived with nothing outstanding
module membus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m0_valid,
  output logic                      m0_ready,
  input  logic [ADDR_W-1:0]         m0_addr,
  input  logic                      m0_wen,
  input  logic [DATA_W-1:0]         m0_wdata,
  input  logic [DATA_W/8-1:0]       m0_wmask,
  output logic                      m0_rvalid,
  output logic [DATA_W-1:0]         m0_rdata,
  input  logic                      m1_valid,
  output logic                      m1_ready,
  input  logic [ADDR_W-1:0]         m1_addr,
  input  logic                      m1_wen,
  input  logic [DATA_W-1:0]         m1_wdata,
  input  logic [DATA_W/8-1:0]       m1_wmask,
  output logic                      m1_rvalid,
  output logic [DATA_W-1:0]         m1_rdata,
  output logic                      s_valid,
  input  logic                      s_ready,
  output logic [ADDR_W-1:0]         s_addr,
  output logic                      s_wen,
  output logic [DATA_W-1:0]         s_wdata,
  output logic [DATA_W/8-1:0]       s_wmask,
  input  logic                      s_rvalid,
  input  logic [DATA_W-1:0]         s_rdata,
  output logic [$clog2(DEPTH):0]    outstanding,
  output logic                      err_orphan
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } arb_state_e;

  arb_state_e       state_q;
  logic             lock_id_q;
  logic             last_grant_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             err_orphan_q;
  logic             fifo_q [DEPTH];

  logic grant;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic head;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = fifo_q[rd_ptr_q];

  always_comb begin
    grant = last_grant_q;
    if (state_q == ARB_LOCKED) begin
      grant = lock_id_q;
    end else if (m0_valid && m1_valid) begin
      grant = ~last_grant_q;
    end else if (m0_valid) begin
      grant = 1'b0;
    end else if (m1_valid) begin
      grant = 1'b1;
    end
  end

  assign s_valid = (grant ? m1_valid : m0_valid) & ~full & ~rst;
  assign s_addr  = grant ? m1_addr  : m0_addr;
  assign s_wen   = grant ? m1_wen   : m0_wen;
  assign s_wdata = grant ? m1_wdata : m0_wdata;
  assign s_wmask = grant ? m1_wmask : m0_wmask;

  assign push     = s_valid & s_ready;
  assign m0_ready = push & ~grant;
  assign m1_ready = push & grant;

  // Responses are steered by the FIFO head; data is broadcast to both ports.
  assign pop       = s_rvalid & ~empty & ~rst;
  assign m0_rvalid = pop & ~head;
  assign m1_rvalid = pop & head;
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign outstanding = count_q;
  assign err_orphan  = err_orphan_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_OPEN;
      lock_id_q    <= 1'b0;
      last_grant_q <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q     <= wr_ptr_q + 1'b1;
        last_grant_q <= grant;
        state_q      <= ARB_OPEN;
      end else if (s_valid) begin
        // Stalled request: pin the choice so the downstream fields stay stable.
        state_q   <= ARB_LOCKED;
        lock_id_q <= grant;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (s_rvalid && empty) begin
        err_orphan_q <= 1'b1;
      end
    end
  end

  // Grant-ID storage needs no reset: occupancy is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= grant;
    end
  end

endmodule

// File: tb/tb_membus_arbiter.sv
module tb_membus_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int MASK_W = DATA_W / 8;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              m0_valid, m0_ready, m0_wen, m0_rvalid;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic [MASK_W-1:0] m0_wmask;
  logic              m1_valid, m1_ready, m1_wen, m1_rvalid;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic [MASK_W-1:0] m1_wmask;
  logic              s_valid, s_ready, s_wen, s_rvalid;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata, s_rdata;
  logic [MASK_W-1:0] s_wmask;
  logic [$clog2(DEPTH):0] outstanding;
  logic              err_orphan;

  membus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wen(m0_wen),
    .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wen(m1_wen),
    .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wen(s_wen),
    .s_wdata(s_wdata), .s_wmask(s_wmask), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner of each outstanding request in issue order, the
  // round-robin history, the held (stalled) choice, and the orphan flag.
  int owners[$];
  bit m_last = 1'b1;
  bit m_held = 1'b0;
  bit m_held_id = 1'b0;
  bit m_err = 1'b0;
  bit acc0, acc1;

  // Checks one cycle with the currently driven inputs, then advances the model
  // to match the state after the coming clock edge.
  task automatic step();
    bit g, want_sv, want_acc, want_pop;
    int head;
    #3;
    if (m_held)                    g = m_held_id;
    else if (m0_valid && m1_valid) g = !m_last;
    else if (m0_valid)             g = 1'b0;
    else if (m1_valid)             g = 1'b1;
    else                           g = m_last;
    want_sv  = !rst && (owners.size() < DEPTH) && (g ? m1_valid : m0_valid);
    want_acc = want_sv && s_ready;
    want_pop = !rst && s_rvalid && (owners.size() > 0);
    head     = (owners.size() > 0) ? owners[0] : 0;

    check_eq("s_valid", s_valid, want_sv);
    check_eq("m0_ready", m0_ready, want_acc && !g);
    check_eq("m1_ready", m1_ready, want_acc && g);
    check_eq("m0_rvalid", m0_rvalid, want_pop && head == 0);
    check_eq("m1_rvalid", m1_rvalid, want_pop && head == 1);
    check_eq("rdata", {m0_rdata, m1_rdata}, {s_rdata, s_rdata});
    check_eq("s_addr", s_addr, g ? m1_addr : m0_addr);
    check_eq("s_fields", {s_wen, s_wdata, s_wmask},
             g ? {m1_wen, m1_wdata, m1_wmask} : {m0_wen, m0_wdata, m0_wmask});
    check_eq("outstanding", outstanding, owners.size());
    check_eq("err_orphan", err_orphan, m_err);

    acc0 = want_acc && !g;
    acc1 = want_acc && g;
    if (rst) begin
      owners.delete();
      m_last = 1'b1; m_held = 1'b0; m_err = 1'b0;
    end else begin
      if (s_rvalid && owners.size() == 0) m_err = 1'b1;
      if (want_pop) void'(owners.pop_front());
      if (want_acc) begin
        owners.push_back(int'(g));
        m_last = g; m_held = 1'b0;
      end else if (want_sv) begin
        m_held = 1'b1; m_held_id = g;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic new_req0();
    m0_addr = $urandom; m0_wen = $urandom_range(0, 1);
    m0_wdata = {$urandom, $urandom}; m0_wmask = MASK_W'($urandom);
  endtask

  task automatic new_req1();
    m1_addr = $urandom; m1_wen = $urandom_range(0, 1);
    m1_wdata = {$urandom, $urandom}; m1_wmask = MASK_W'($urandom);
  endtask

  task automatic drain();
    m0_valid = 0; m1_valid = 0; s_ready = 0;
    for (int i = 0; i < 20 && owners.size() > 0; i++) begin
      s_rvalid = 1; s_rdata = {$urandom, $urandom};
      step();
    end
    s_rvalid = 0;
    check_eq("drain_empty", outstanding, 0);
  endtask

  initial begin
    rst = 1; m0_valid = 1; m1_valid = 0; s_ready = 1; s_rvalid = 0; s_rdata = '0;
    new_req0(); new_req1();
    @(posedge clk); #1;

    // Reset held with a pending request
    for (int i = 0; i < 3; i++) step();
    rst = 0; m0_valid = 0;
    check_eq("t1_outstanding", outstanding, 0);

    // Tie: both valid each cycle, responses two cycles later
    m0_valid = 1; m1_valid = 1; s_ready = 1;
    for (int i = 0; i < 4; i++) begin
      s_rvalid = (owners.size() >= 2); s_rdata = {$urandom, $urandom};
      step();
      if (i == 0) check_eq("t2_first_grant", {acc0, acc1}, 2'b10);
      if (acc0) new_req0();
      if (acc1) new_req1();
    end
    m0_valid = 0; m1_valid = 0;
    drain();

    // Stall: m1 granted and held while m0 also requests
    m1_valid = 1; m1_addr = 32'h8000_0010; s_ready = 0;
    step();
    m0_valid = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("t3_addr_held", s_addr, 32'h8000_0010);
    end
    s_ready = 1;
    step();
    check_eq("t3_m1_acc", {acc0, acc1}, 2'b01);
    m1_valid = 0;
    step();
    check_eq("t3_m0_next", {acc0, acc1}, 2'b10);
    m0_valid = 0;
    drain();

    // Full: accepts stop at DEPTH until a response frees a slot
    m0_valid = 1; s_ready = 1;
    for (int i = 0; i < DEPTH + 2; i++) step();
    check_eq("t4_full", outstanding, DEPTH);
    s_rvalid = 1;
    step();
    s_rvalid = 0;
    check_eq("t4_after_pop", outstanding, DEPTH - 1);
    step();
    check_eq("t4_reaccept", acc0, 1'b1);
    m0_valid = 0;
    drain();

    // Steady push+pop with one-cycle response lag
    m1_valid = 1; s_ready = 1; s_rdata = 64'hDEAD_BEEF_0000_0001;
    for (int i = 0; i < 6; i++) begin
      s_rvalid = (i > 0);
      step();
      if (i > 0) check_eq("t5_steady", outstanding, 1);
    end
    m1_valid = 0; s_rvalid = 0;
    drain();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (!m0_valid || rst) begin m0_valid = $urandom_range(0, 2) != 0; new_req0(); end
      if (!m1_valid || rst) begin m1_valid = $urandom_range(0, 2) != 0; new_req1(); end
      s_ready  = $urandom_range(0, 3) != 0;
      s_rvalid = (owners.size() > 0) && ($urandom_range(0, 2) != 0);
      s_rdata  = {$urandom, $urandom};
      step();
      if (acc0) m0_valid = 0;
      if (acc1) m1_valid = 0;
    end
    rst = 0;
    drain();

    // Orphan response sets a sticky error cleared only by reset
    s_rvalid = 1;
    step();
    s_rvalid = 0;
    check_eq("t6_orphan", err_orphan, 1'b1);
    step();
    step();
    rst = 1;
    step();
    rst = 0;
    check_eq("t6_cleared", err_orphan, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
